// File: rtl/l1_data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 2**S_INDEX sets of
// 32-byte lines in flops, same-cycle hits, writeback/allocate miss engine.

module l1_dcache_set #(
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [255:0]     fill_data,
    input  logic             wr_en,
    input  logic [2:0]       wr_word,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             clean_en,
    output logic             valid,
    output logic             dirty,
    output logic [TAG_W-1:0] tag,
    output logic [255:0]     data
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            dirty <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
            dirty <= 1'b0;
        end else if (wr_en) begin
            dirty <= 1'b1;
        end else if (clean_en) begin
            dirty <= 1'b0;
        end
    end

    // Tag/data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag  <= fill_tag;
            data <= fill_data;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    data[{wr_word, b[1:0], 3'b000} +: 8] <= wr_data[8*b +: 8];
            end
        end
    end
endmodule

module l1_data_cache #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         hit,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int NSETS = 2**S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [S_INDEX-1:0] idx;
    } miss_t;

    state_t state;
    miss_t  miss_q;

    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [2:0]         req_word;
    logic               req;
    logic               unused_addr_lsb;

    assign req_tag         = mem_address[31:5+S_INDEX];
    assign req_idx         = mem_address[4+S_INDEX:5];
    assign req_word        = mem_address[4:2];
    assign req             = mem_read | mem_write;
    assign unused_addr_lsb = ^mem_address[1:0];

    logic [NSETS-1:0]             set_valid, set_dirty;
    logic [NSETS-1:0][TAG_W-1:0]  set_tag;
    logic [NSETS-1:0][255:0]      set_data;
    logic [NSETS-1:0]             fill_sel, wr_sel, clean_sel;

    assign hit       = (state == IDLE) && req && set_valid[req_idx] && (set_tag[req_idx] == req_tag);
    assign mem_resp  = hit;
    assign mem_rdata = hit ? set_data[req_idx][32*req_word +: 32] : '0;

    // pmem strobes decode straight from state so an async reset drops them at once.
    assign pmem_read  = (state == ALLOCATE);
    assign pmem_write = (state == WRITEBACK);
    assign pmem_wdata = pmem_write ? set_data[miss_q.idx] : '0;

    always_comb begin
        pmem_address = '0;
        if (pmem_write)
            pmem_address = {set_tag[miss_q.idx], miss_q.idx, 5'b0};
        else if (pmem_read)
            pmem_address = {miss_q.tag, miss_q.idx, 5'b0};
    end

    always_comb begin
        fill_sel  = '0;
        wr_sel    = '0;
        clean_sel = '0;
        if (pmem_read && pmem_resp)
            fill_sel[miss_q.idx] = 1'b1;
        if (pmem_write && pmem_resp)
            clean_sel[miss_q.idx] = 1'b1;
        // Read and write together is treated as a write.
        if (hit && mem_write)
            wr_sel[req_idx] = 1'b1;
    end

    for (genvar g = 0; g < NSETS; g++) begin : g_set
        l1_dcache_set #(.TAG_W(TAG_W)) u_set (
            .clk       (clk),
            .rst       (rst),
            .fill_en   (fill_sel[g]),
            .fill_tag  (miss_q.tag),
            .fill_data (pmem_rdata),
            .wr_en     (wr_sel[g]),
            .wr_word   (req_word),
            .wr_be     (mem_byte_enable),
            .wr_data   (mem_wdata),
            .clean_en  (clean_sel[g]),
            .valid     (set_valid[g]),
            .dirty     (set_dirty[g]),
            .tag       (set_tag[g]),
            .data      (set_data[g])
        );
    end

    // Miss target is latched so a dropped request still finishes its fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            miss_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        miss_q <= '{tag: req_tag, idx: req_idx};
                        state  <= (set_valid[req_idx] && set_dirty[req_idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: if (pmem_resp) state <= ALLOCATE;
                ALLOCATE:  if (pmem_resp) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_data_cache.sv
// Bench for l1_data_cache: directed scenarios plus random traffic checked
// against a flat-memory golden model and a line-residency model.

module tb_l1_data_cache;
    localparam int S_INDEX = 3;
    localparam int NSETS   = 2**S_INDEX;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp, hit, pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp;
    logic         resp_mem = 1'b0;
    logic         stray = 1'b0;

    assign pmem_resp = resp_mem | stray;
    always #5 clk = ~clk;

    l1_data_cache #(.S_INDEX(S_INDEX)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .hit(hit),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 0;
    int cnt = 0;

    typedef struct { logic [31:0] addr; logic [255:0] data; } wb_t;
    wb_t         wb_q[$];
    logic [31:0] rd_q[$];

    logic [31:0] mem_w [int unsigned];   // backing store, by byte address of word
    logic [31:0] gold  [int unsigned];   // CPU-visible memory contents
    bit          r_valid [NSETS];
    bit          r_dirty [NSETS];
    logic [31:0] r_line  [NSETS];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h1111_1111;
        if (a == 32'h44) return 32'h1122_3344;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_w.exists(a) ? mem_w[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : mem_word(a);
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(base + 32'(4*k));
        return l;
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = gold_word(base + 32'(4*k));
        return l;
    endfunction

    // Physical memory responder with programmable wait cycles.
    always @(negedge clk) begin
        if (!rst) begin
            resp_mem = 1'b0;
            cnt = 0;
        end else begin
            if (resp_mem) begin
                resp_mem = 1'b0;
                cnt = 0;
            end
            if (pmem_read || pmem_write) begin
                if (cnt >= mem_lat) begin
                    resp_mem = 1'b1;
                    if (pmem_write) begin
                        wb_q.push_back('{pmem_address, pmem_wdata});
                        for (int k = 0; k < 8; k++) mem_w[pmem_address + 32'(4*k)] = pmem_wdata[32*k +: 32];
                    end else begin
                        rd_q.push_back(pmem_address);
                        pmem_rdata = mem_line(pmem_address);
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Reference: a cache is transparent, so data comes from gold; residency predicts timing.
    task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be, output bit exp_hit, output bit exp_wb,
                                output logic [31:0] victim);
        int idx = int'(a[4+S_INDEX:5]);
        logic [31:0] base = {a[31:5], 5'b0};
        logic [31:0] w;
        exp_hit = r_valid[idx] && (r_line[idx] == base);
        exp_wb  = !exp_hit && r_valid[idx] && r_dirty[idx];
        victim  = r_line[idx];
        if (!exp_hit) begin
            r_valid[idx] = 1'b1;
            r_dirty[idx] = 1'b0;
            r_line[idx]  = base;
        end
        if (wr) begin
            r_dirty[idx] = 1'b1;
            w = gold_word({a[31:2], 2'b00});
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            gold[{a[31:2], 2'b00}] = w;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSETS; i++) begin
            r_valid[i] = 1'b0;
            r_dirty[i] = 1'b0;
        end
        gold.delete();
    endtask

    task automatic cpu_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, output logic [31:0] rd, output int cyc,
                              output bit hit0, output bit hit_resp, output bit proto_ok,
                              output int rd_hi, output bit done);
        rd = '0; cyc = 0; hit0 = 0; hit_resp = 0; proto_ok = 1; rd_hi = 0; done = 0;
        @(posedge clk); #1;
        mem_read = !wr; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (i == 0) hit0 = hit;
            if (pmem_read) rd_hi++;
            if (pmem_read && pmem_write) proto_ok = 0;
            if (mem_resp && (pmem_read || pmem_write)) proto_ok = 0;
            if (mem_resp) begin
                rd = mem_rdata;
                hit_resp = hit;
                done = 1;
            end
        end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (mem_resp !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
        n_cmp++; if (hit !== 1'b0)        begin n_bad++; $display("FAIL reset_hit: got %b want 0", hit); end
        n_cmp++; if (pmem_read !== 1'b0)  begin n_bad++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
        n_cmp++; if (pmem_write !== 1'b0) begin n_bad++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
        n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_rdata: got %h want 0", mem_rdata); end
        mem_read = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_clean_miss();
        logic [31:0] rd, v; int cyc, rh; bit h0, hr, pok, done, eh, ew;
        int rq0 = rd_q.size();
        mem_lat = 0;
        model_access(0, 32'h40, 0, 0, eh, ew, v);
        cpu_access(0, 32'h40, 0, 0, rd, cyc, h0, hr, pok, rh, done);
        n_cmp++; if (!done) begin n_bad++; $display("FAIL clean_miss_done: no mem_resp"); end
        n_cmp++; if (rd !== 32'h1111_1111) begin n_bad++; $display("FAIL clean_miss_rdata: got %h want 11111111", rd); end
        n_cmp++; if (h0 !== 1'b0 || hr !== 1'b1) begin n_bad++; $display("FAIL clean_miss_hit: first %b resp %b want 0/1", h0, hr); end
        n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL clean_miss_latency: got %0d want 3", cyc); end
        n_cmp++; if (rd_q.size() != rq0 + 1 || rd_q[rd_q.size()-1] !== 32'h40)
            begin n_bad++; $display("FAIL clean_miss_pmem_addr: fills %0d last %h want 1 at 00000040", rd_q.size() - rq0, rd_q[rd_q.size()-1]); end
        n_cmp++; if (!pok) begin n_bad++; $display("FAIL clean_miss_proto: got 0 want 1"); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd, v; int cyc, rh; bit h0, hr, pok, done, eh, ew;
        model_access(1, 32'h44, 32'hAABB_CCDD, 4'b0101, eh, ew, v);
        cpu_access(1, 32'h44, 32'hAABB_CCDD, 4'b0101, rd, cyc, h0, hr, pok, rh, done);
        n_cmp++; if (!done || cyc != 1 || h0 !== 1'b1)
            begin n_bad++; $display("FAIL write_hit_latency: done %b cyc %0d hit %b want 1/1/1", done, cyc, h0); end
        cpu_access(0, 32'h44, 0, 0, rd, cyc, h0, hr, pok, rh, done);
        n_cmp++; if (rd !== 32'h11BB_33DD) begin n_bad++; $display("FAIL write_hit_merge: got %h want 11bb33dd", rd); end
        n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL write_hit_readback_latency: got %0d want 1", cyc); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd, v, exp_rd; logic [255:0] exp_line; int cyc, rh; bit h0, hr, pok, done, eh, ew;
        int wq0 = wb_q.size();
        int rq0 = rd_q.size();
        exp_line = gold_line(32'h40);
        exp_rd = gold_word(32'h140);
        model_access(0, 32'h140, 0, 0, eh, ew, v);
        cpu_access(0, 32'h140, 0, 0, rd, cyc, h0, hr, pok, rh, done);
        n_cmp++; if (wb_q.size() != wq0 + 1) begin n_bad++; $display("FAIL evict_wb_count: got %0d want 1", wb_q.size() - wq0); end
        else begin
            n_cmp++; if (wb_q[wq0].addr !== 32'h40) begin n_bad++; $display("FAIL evict_wb_addr: got %h want 00000040", wb_q[wq0].addr); end
            n_cmp++; if (wb_q[wq0].data[63:32] !== 32'h11BB_33DD) begin n_bad++; $display("FAIL evict_wb_word1: got %h want 11bb33dd", wb_q[wq0].data[63:32]); end
            n_cmp++; if (wb_q[wq0].data !== exp_line) begin n_bad++; $display("FAIL evict_wb_line: got %h want %h", wb_q[wq0].data, exp_line); end
        end
        n_cmp++; if (rd_q.size() != rq0 + 1 || rd_q[rd_q.size()-1] !== 32'h140)
            begin n_bad++; $display("FAIL evict_fill_addr: fills %0d last %h want 1 at 00000140", rd_q.size() - rq0, rd_q[rd_q.size()-1]); end
        n_cmp++; if (rd !== exp_rd || cyc != 4) begin n_bad++; $display("FAIL evict_read: got %h/%0d want %h/4", rd, cyc, exp_rd); end
    endtask

    task automatic test_stall();
        logic [31:0] rd, v, exp_rd; int cyc, rh; bit h0, hr, pok, done, eh, ew;
        int act0 = wb_q.size() + rd_q.size();
        @(posedge clk); #1; stray = 1'b1;
        @(posedge clk); #1; stray = 1'b0;
        n_cmp++; if (wb_q.size() + rd_q.size() != act0 || pmem_read || pmem_write)
            begin n_bad++; $display("FAIL stray_resp_idle: pmem activity %0d rd %b wr %b want none", wb_q.size() + rd_q.size() - act0, pmem_read, pmem_write); end
        model_access(0, 32'h140, 0, 0, eh, ew, v);
        cpu_access(0, 32'h140, 0, 0, rd, cyc, h0, hr, pok, rh, done);
        n_cmp++; if (cyc != 1 || h0 !== 1'b1) begin n_bad++; $display("FAIL stray_then_hit: cyc %0d hit %b want 1/1", cyc, h0); end
        mem_lat = 10;
        exp_rd = gold_word(32'h2A0);
        model_access(0, 32'h2A0, 0, 0, eh, ew, v);
        cpu_access(0, 32'h2A0, 0, 0, rd, cyc, h0, hr, pok, rh, done);
        mem_lat = 0;
        n_cmp++; if (rh != 11 || cyc != 13) begin n_bad++; $display("FAIL stall_alloc_cycles: pmem_read %0d total %0d want 11/13", rh, cyc); end
        n_cmp++; if (!pok) begin n_bad++; $display("FAIL stall_resp_during_alloc: got 0 want 1"); end
        n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL stall_rdata: got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_reset_mid_wb();
        logic [31:0] rd, v, exp_rd; int cyc, rh; bit h0, hr, pok, done, eh, ew, seen;
        model_access(1, 32'h2A8, 32'hDEAD_BEEF, 4'hF, eh, ew, v);
        cpu_access(1, 32'h2A8, 32'hDEAD_BEEF, 4'hF, rd, cyc, h0, hr, pok, rh, done);
        mem_lat = 50;
        seen = 0;
        @(posedge clk); #1;
        mem_read = 1; mem_address = 32'h4A0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (pmem_write) seen = 1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL midwb_enter: pmem_write got 0 want 1"); end
        #2; rst = 1'b0;
        #1;
        n_cmp++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0)
            begin n_bad++; $display("FAIL midwb_async_drop: rd %b wr %b want 0/0", pmem_read, pmem_write); end
        mem_read = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_lat = 0;
        model_reset();
        exp_rd = gold_word(32'h2A8);
        model_access(0, 32'h2A8, 0, 0, eh, ew, v);
        cpu_access(0, 32'h2A8, 0, 0, rd, cyc, h0, hr, pok, rh, done);
        n_cmp++; if (h0 !== 1'b0) begin n_bad++; $display("FAIL midwb_invalidated: hit %b want 0", h0); end
        n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL midwb_old_data: got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, exp; int pulses = 0; bit bad_pm = 0;
        int act0 = wb_q.size() + rd_q.size();
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            a = 32'h2A0 + 32'(4*k);
            mem_read = 1; mem_address = a;
            exp = gold_word(a);
            @(negedge clk);
            if (mem_resp) pulses++;
            if (pmem_read || pmem_write) bad_pm = 1;
            n_cmp++; if (mem_rdata !== exp) begin n_bad++; $display("FAIL b2b_word%0d: got %h want %h", k, mem_rdata, exp); end
            @(posedge clk); #1;
        end
        mem_read = 0;
        n_cmp++; if (pulses != 8) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 8", pulses); end
        n_cmp++; if (bad_pm || wb_q.size() + rd_q.size() != act0)
            begin n_bad++; $display("FAIL b2b_no_pmem: got %0d transfers want 0", wb_q.size() + rd_q.size() - act0); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, v, exp_rd; logic [255:0] exp_line; logic [3:0] be;
        int cyc, rh, lat, wq0, exp_cyc; bit wr, h0, hr, pok, done, eh, ew;
        for (int n = 0; n < 150; n++) begin
            lat = $urandom_range(0, 3);
            mem_lat = lat;
            a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) | (32'($urandom_range(0, 7)) << 2);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            exp_rd = gold_word(a);
            wq0 = wb_q.size();
            model_access(wr, a, wd, be, eh, ew, v);
            exp_line = gold_line(v);
            exp_cyc = 1 + (eh ? 0 : lat + 2) + (ew ? lat + 1 : 0);
            cpu_access(wr, a, wd, be, rd, cyc, h0, hr, pok, rh, done);
            n_cmp++; if (!done || cyc != exp_cyc || h0 !== eh || !pok)
                begin n_bad++; $display("FAIL rand%0d_timing: addr %h done %b cyc %0d hit %b proto %b want 1/%0d/%b/1", n, a, done, cyc, h0, pok, exp_cyc, eh); end
            if (!wr) begin
                n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rand%0d_rdata: addr %h got %h want %h", n, a, rd, exp_rd); end
            end
            n_cmp++; if (wb_q.size() - wq0 != int'(ew))
                begin n_bad++; $display("FAIL rand%0d_wb_count: addr %h got %0d want %0d", n, a, wb_q.size() - wq0, ew); end
            else if (ew) begin
                n_cmp++; if (wb_q[wq0].addr !== v || wb_q[wq0].data !== exp_line)
                    begin n_bad++; $display("FAIL rand%0d_wb_line: got %h want %h", n, wb_q[wq0].addr, v); end
            end
        end
        mem_lat = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        mem_read = 1; mem_write = 0; mem_address = 32'h40; mem_wdata = '0; mem_byte_enable = '0;
        model_reset();
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_evict();
        test_stall();
        test_reset_mid_wb();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l1_data_cache.md
Name: l1_data_cache

Overview:
- Direct-mapped, write-back, write-allocate cache.
- Acts as the responder on the CPU data port: it accepts read/write requests with byte enables and returns resp/rdata.
- Acts as the initiator on a 256-bit line-wide physical memory port toward main memory/arbiter.
- Hits complete in the same cycle; misses run a writeback/allocate state machine.

Parameters:
S_INDEX, 3, index bits; set count = 2**S_INDEX (line = 32 bytes, 8 words, fixed)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
mem_byte_enable  input  4  byte lanes for writes
mem_address  input  32  byte address; bits [1:0] ignored
mem_wdata  input  32  write data
mem_rdata  output  32  read data, valid when mem_resp=1
mem_resp  output  1  one-cycle completion pulse per request
hit  output  1  request present in IDLE and tag matches a valid line
pmem_read  output  1  line fill request, held until pmem_resp
pmem_write  output  1  line writeback request, held until pmem_resp
pmem_address  output  32  line-aligned address, bits [4:0]=0
pmem_wdata  output  256  victim line
pmem_rdata  input  256  fill line, valid with pmem_resp
pmem_resp  input  1  physical memory completion

Behaviour:
Address split:
- tag = addr[31:5+S_INDEX]
- index = addr[4+S_INDEX:5]
- word = addr[4:2], selecting bits [32*word+31 : 32*word] of the line.

Storage:
- Per-set valid, dirty, tag and 256-bit data, all held in flops.
- Reset (rst=0, asynchronous):
  - all valid and dirty bits = 0; state = IDLE.
  - mem_resp, hit, pmem_read, pmem_write = 0; mem_rdata = 0.
  - tag and data contents are don't-care.

States: IDLE, WRITEBACK, ALLOCATE.

IDLE:
- Read hit: mem_resp=1 and mem_rdata = selected word, both combinational in the same cycle. No state change.
- Write hit: mem_resp=1 combinationally. On the clock edge, bytes with mem_byte_enable[i]=1 are written to byte lane i of the selected word, and dirty=1. Other bytes are unchanged.
- Miss with victim valid and dirty:
  - Go to WRITEBACK.
  - pmem_address = {victim tag, index, 5'b0}.
  - pmem_wdata = victim line.
- Miss otherwise: go to ALLOCATE.
- No request: idle, all outputs 0.
- mem_read and mem_write both high is illegal from the CPU; the cache treats it as a write.

WRITEBACK:
- pmem_write=1 is held until pmem_resp.
- On the pmem_resp edge: dirty=0, then go to ALLOCATE.

ALLOCATE:
- pmem_read=1 with pmem_address = {req tag, index, 5'b0}, held until pmem_resp.
- On the pmem_resp edge: data=pmem_rdata, tag=req tag, valid=1, dirty=0, then go to IDLE.
- The request then hits in IDLE on the following cycle, so mem_resp comes on the cycle after the fill.

General rules:
- mem_resp=0 in WRITEBACK and ALLOCATE.
- pmem_read and pmem_write are never high together.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- Miss latency: 1 + fill + (writeback if dirty) cycles.
- Minimum clean miss: request cycle, ≥1 ALLOCATE cycle, then a hit cycle.
- The CPU holds address/data stable until mem_resp. If the request drops mid-miss, the fill still completes and the cache returns to IDLE with no mem_resp.
- Reset during WRITEBACK or ALLOCATE: pmem_read/pmem_write drop immediately (asynchronous), the operation is abandoned and no partial line is written.
- Index wrap: addresses differing only above the index bits map to the same set and evict each other.

Test Plan:
- Reset then read 0x0000_0040 (clean miss; memory line word0=0x1111_1111): pmem_read=1, pmem_address=0x0000_0040. After pmem_resp, the next cycle has mem_resp=1, mem_rdata=0x1111_1111, hit=1.
- Write 0x0000_0044 with wdata 0xAABB_CCDD and mbe=4'b0101 to a resident line whose old word=0x1122_3344: mem_resp is the same cycle. A subsequent read returns 0x11BB_33DD and the line is dirty.
- Read 0x0000_0140 (same index as 0x40 when S_INDEX=3, different tag) after the dirty write:
  - pmem_write=1, pmem_address=0x0000_0040, pmem_wdata word1=0x11BB_33DD.
  - Then pmem_read with pmem_address=0x0000_0140.
  - Then mem_resp.
- Hold pmem_resp=0 for 10 cycles during ALLOCATE: pmem_read stays 1 and mem_resp stays 0 throughout. A pmem_resp pulsed in IDLE earlier had no effect.
- Assert rst=0 mid-WRITEBACK: pmem_write falls without a clock edge. After release, a read to the old address misses (valid=0).
- Back-to-back hits to words 0..7 of one line, one per cycle: 8 mem_resp pulses and no pmem activity.
